// File: rtl/led_pkg.sv
// Shared types for the LED frame controller.
//   ROWS / ROW_W : matrix geometry (4 rows x 8 LEDs)
//   row_idx_t    : row selector
//   row_data_t   : one row of LED bits, bit n = LED n+1
//   swap_state_t : back->front swap FSM states
package led_pkg;
  localparam int ROWS  = 4;
  localparam int ROW_W = 8;

  typedef logic [1:0]       row_idx_t;
  typedef logic [ROW_W-1:0] row_data_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } swap_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk12MHz  in   clock
//   reset     in   synchronous active-high reset (req[0] wins first tie)
//   req[1:0]  in   request lines
//   gnt[1:0]  out  combinational one-hot (or zero) grant
module rr_arbiter2 (
  input  logic       clk12MHz,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // 1 = requester 0 was granted most recently
  logic last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk12MHz) begin
    if (reset)     last <= 1'b0;
    else if (|gnt) last <= gnt[0];
  end
endmodule

// File: rtl/led_frame_ctrl.sv
// Double-buffered frame controller for the 4x8 LED matrix.
//   clk12MHz, reset               clock, synchronous active-high reset
//   a_req/a_row/a_data/a_ack      writer A (held until ack; ack = commit edge)
//   b_req/b_row/b_data/b_ack      writer B
//   swap_req                      pulse: copy back->front at next frame boundary
//   swap_pending, swap_done       swap status (registered)
//   frame_tick                    last cycle of each frame (combinational)
//   leds1..leds4                  front buffer rows 0..3
module led_frame_ctrl
  import led_pkg::*;
#(
  parameter int FRAME_CYCLES = 4096
) (
  input  logic      clk12MHz,
  input  logic      reset,
  input  logic      a_req,
  input  row_idx_t  a_row,
  input  row_data_t a_data,
  output logic      a_ack,
  input  logic      b_req,
  input  row_idx_t  b_row,
  input  row_data_t b_data,
  output logic      b_ack,
  input  logic      swap_req,
  output logic      swap_pending,
  output logic      swap_done,
  output logic      frame_tick,
  output row_data_t leds1,
  output row_data_t leds2,
  output row_data_t leds3,
  output row_data_t leds4
);
  localparam int TW = $clog2(FRAME_CYCLES);

  logic [TW-1:0] timer;
  row_data_t     back  [ROWS];
  row_data_t     front [ROWS];
  swap_state_t   state;
  logic [1:0]    gnt;
  logic          wr_en, copy;
  row_idx_t      wr_row;
  row_data_t     wr_data;

  rr_arbiter2 u_arb (
    .clk12MHz (clk12MHz),
    .reset    (reset),
    .req      ({b_req, a_req}),
    .gnt      (gnt)
  );

  // No commit happens while reset is asserted, so no ack either.
  assign a_ack   = gnt[0] & ~reset;
  assign b_ack   = gnt[1] & ~reset;
  assign wr_en   = a_ack | b_ack;
  assign wr_row  = a_ack ? a_row  : b_row;
  assign wr_data = a_ack ? a_data : b_data;

  assign frame_tick = (timer == TW'(FRAME_CYCLES - 1));
  // A request landing on the tick itself is served immediately.
  assign copy = frame_tick & ((state == PENDING) | swap_req);

  assign leds1 = front[0];
  assign leds2 = front[1];
  assign leds3 = front[2];
  assign leds4 = front[3];

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      timer        <= '0;
      state        <= IDLE;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        back[i]  <= '0;
        front[i] <= '0;
      end
    end else begin
      timer     <= frame_tick ? '0 : timer + 1'b1;
      swap_done <= copy;
      // Copy samples back before this edge's write lands.
      if (copy) front <= back;
      if (wr_en) back[wr_row] <= wr_data;
      case (state)
        IDLE: if (swap_req && !frame_tick) begin
          state        <= PENDING;
          swap_pending <= 1'b1;
        end
        PENDING: if (frame_tick) begin
          state        <= IDLE;
          swap_pending <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_frame_ctrl.sv
module tb_led_frame_ctrl;
  localparam int FC = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req, swap_req;
  logic [1:0] a_row, b_row;
  logic [7:0] a_data, b_data;
  logic       a_ack, b_ack, swap_pending, swap_done, frame_tick;
  logic [7:0] leds1, leds2, leds3, leds4;

  int checks = 0;
  int fails  = 0;

  led_frame_ctrl #(.FRAME_CYCLES(FC)) dut (
    .clk12MHz(clk), .reset(reset),
    .a_req(a_req), .a_row(a_row), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_row(b_row), .b_data(b_data), .b_ack(b_ack),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .frame_tick(frame_tick),
    .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         mdl_on = 0;
  int         t_m;          // position inside the current frame
  int         last_w;       // 0 none, 1 A, 2 B: most recent winner
  bit         pend_m, done_m;
  logic [7:0] bk_m [4];
  logic [7:0] fr_m [4];

  // returns {b_granted, a_granted}
  function automatic logic [1:0] winner(input logic ar, input logic br, input int lw);
    if (ar && br) return (lw == 1) ? 2'b10 : 2'b01;
    if (ar) return 2'b01;
    if (br) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    logic [1:0] w;
    bit tk, cp;
    if (reset) begin
      mdl_on = 1; t_m = 0; last_w = 0; pend_m = 0; done_m = 0;
      for (int i = 0; i < 4; i++) begin bk_m[i] = 8'h00; fr_m[i] = 8'h00; end
    end else if (mdl_on) begin
      w  = winner(a_req, b_req, last_w);
      tk = (t_m == FC - 1);
      cp = tk && (pend_m || swap_req);
      if (cp) for (int i = 0; i < 4; i++) fr_m[i] = bk_m[i];
      done_m = cp;
      if (w[0]) begin bk_m[a_row] = a_data; last_w = 1; end
      else if (w[1]) begin bk_m[b_row] = b_data; last_w = 2; end
      pend_m = tk ? 0 : (pend_m || swap_req);
      t_m = (t_m + 1) % FC;
    end
  end

  always @(negedge clk) begin
    logic [1:0] w;
    if (mdl_on) begin
      w = reset ? 2'b00 : winner(a_req, b_req, last_w);
      chk("m_a_ack", a_ack, w[0]);
      chk("m_b_ack", b_ack, w[1]);
      chk("m_tick", frame_tick, t_m == FC - 1);
      chk("m_pending", swap_pending, pend_m);
      chk("m_done", swap_done, done_m);
      chk("m_leds1", leds1, fr_m[0]);
      chk("m_leds2", leds2, fr_m[1]);
      chk("m_leds3", leds3, fr_m[2]);
      chk("m_leds4", leds4, fr_m[3]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (t_m != target && n < 2 * FC) begin step(); n++; end
    chk("wait_timer", t_m, target);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1; step(); swap_req = 1'b0;
  endtask

  task automatic write_a(input logic [1:0] r, input logic [7:0] d);
    int n = 0;
    a_req = 1'b1; a_row = r; a_data = d; #1;
    while (!a_ack && n < 8) begin step(); n++; end
    chk("write_a_ack", a_ack, 1);
    step(); a_req = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin step(); if (swap_done) cnt++; end
  endtask

  initial begin
    int cnt;
    bit ga, gb;
    reset = 1; a_req = 0; b_req = 0; swap_req = 0;
    a_row = 0; b_row = 0; a_data = 0; b_data = 0;

    // reset values and first tick position
    repeat (3) step();
    chk("rst_leds", {leds1, leds2, leds3, leds4}, 0);
    chk("rst_outs", {a_ack, b_ack, swap_pending, swap_done}, 0);
    reset = 0;
    repeat (FC - 2) step();
    chk("tick_early", frame_tick, 0);
    step();
    chk("tick_first", frame_tick, 1);
    step();

    // basic write + swap
    write_a(2'd2, 8'hA5);
    wait_t(100);
    pulse_swap();
    chk("basic_pending", swap_pending, 1);
    wait_t(FC - 1);
    chk("basic_old", leds3, 8'h00);
    step();
    chk("basic_leds3", leds3, 8'hA5);
    chk("basic_others", {leds1, leds2, leds4}, 0);
    chk("basic_done", swap_done, 1);
    chk("basic_pend_clr", swap_pending, 0);
    step();
    chk("basic_done_pulse", swap_done, 0);

    // contention from reset
    reset = 1; step(); reset = 0;
    a_req = 1; a_row = 0; a_data = 8'h01;
    b_req = 1; b_row = 1; b_data = 8'h02; #1;
    chk("rr0", {b_ack, a_ack}, 2'b01); step();
    chk("rr1", {b_ack, a_ack}, 2'b10); step();
    chk("rr2", {b_ack, a_ack}, 2'b01); step();
    chk("rr3", {b_ack, a_ack}, 2'b10); step();
    a_req = 0; #1;
    repeat (3) begin chk("b_alone", b_ack, 1); step(); end
    b_req = 0;

    // write in the copy cycle
    pulse_swap();
    wait_t(FC - 1);
    b_req = 1; b_row = 0; b_data = 8'hFF; #1;
    chk("copy_cyc_ack", b_ack, 1);
    step(); b_req = 0;
    chk("copy_cyc_old", leds1, 8'h01);
    chk("copy_cyc_row1", leds2, 8'h02);
    pulse_swap();
    wait_t(FC - 1);
    step();
    chk("copy_cyc_next", leds1, 8'hFF);

    // swap_req coincident with frame_tick
    write_a(2'd3, 8'h3C);
    wait_t(FC - 1);
    swap_req = 1; #1;
    chk("coinc_pend0", swap_pending, 0);
    step(); swap_req = 0;
    chk("coinc_leds4", leds4, 8'h3C);
    chk("coinc_done", swap_done, 1);
    repeat (3) begin chk("coinc_pend", swap_pending, 0); step(); end

    // three requests in one frame -> one copy
    wait_t(10);  pulse_swap();
    wait_t(50);  pulse_swap();
    wait_t(200); pulse_swap();
    count_done(FC + 4, cnt);
    chk("merge_done_cnt", cnt, 1);

    // reset while pending
    wait_t(5); pulse_swap();
    wait_t(FC / 2);
    chk("midrst_pend", swap_pending, 1);
    reset = 1; step(); reset = 0;
    chk("midrst_pend_clr", swap_pending, 0);
    chk("midrst_leds", {leds1, leds2, leds3, leds4}, 0);
    count_done(FC + 4, cnt);
    chk("midrst_no_done", cnt, 0);
    chk("midrst_leds_after", {leds1, leds2, leds3, leds4}, 0);

    // randomized traffic against the model
    repeat (3 * FC) begin
      ga = a_ack; gb = b_ack;
      step();
      if (ga) a_req = 0;
      if (gb) b_req = 0;
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1; a_row = 2'($urandom_range(0, 3)); a_data = 8'($urandom);
      end
      if (!b_req && $urandom_range(0, 2) == 0) begin
        b_req = 1; b_row = 2'($urandom_range(0, 3)); b_data = 8'($urandom);
      end
      swap_req = ($urandom_range(0, 299) == 0);
      reset    = ($urandom_range(0, 1999) == 0);
    end
    a_req = 0; b_req = 0; swap_req = 0; reset = 0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
